acc_seq_sched: RTL and testbench

- Command scheduler for the 8-bit load/increment accumulator datapath (synchronous active-low reset, load, inc, in_data, out_data).
- Arbitrates NUM_REQ requesters round-robin, accepts one command at a time, and sequences the datapath's load/inc/reset pins cycle by cycle.
- Returns the resulting accumulator value to the winning requester.
- Sits directly in front of the accumulator; it is the only driver of the accumulator's control inputs.

---
 rtl/acc_seq_sched_pkg.sv | 27 ++
 rtl/acc_seq_sched_rr_arbiter.sv | 46 ++++
 rtl/acc_seq_sched.sv | 210 +++++++++++++++++++++
 tb/tb_acc_seq_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_sched_pkg.sv
// ---------------------------------------------------------------------------
// acc_seq_pkg
//   Shared types and constants for the accumulator command scheduler.
//   - op_e    : requester opcode (CLR, LOAD, STEP, NOP), 2 bits.
//   - state_e : scheduler FSM states (IDLE, EXEC, RESP).
//   - ACC_W   : accumulator data width.
//   - CNT_W   : STEP repeat-count width.
// ---------------------------------------------------------------------------
package acc_seq_pkg;

    localparam int ACC_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        NOP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/acc_seq_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Searches i_req starting at
//   i_ptr and wrapping, and returns the first set bit.
//   Ports:
//     i_req   [NUM_REQ] request vector
//     i_ptr   [ID_W]    index with highest priority this cycle
//     i_en    [1]       when low, nothing is granted
//     o_grant [NUM_REQ] one-hot grant
//     o_idx   [ID_W]    encoded index of the granted requester
//     o_any   [1]       a grant was made
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;

    // Walk the requesters in priority order; the first hit wins and
    // later candidates are ignored through o_any.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        if (i_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand = ID_W'((int'(i_ptr) + i) % NUM_REQ);
                if (!o_any && i_req[w_cand]) begin
                    o_any           = 1'b1;
                    o_idx           = w_cand;
                    o_grant[w_cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/acc_seq_sched.sv
// ---------------------------------------------------------------------------
// acc_seq_sched
//   Round-robin command scheduler in front of an 8-bit load/increment
//   accumulator. Accepts one command at a time, sequences the
//   accumulator's reset_l/load/inc pins, and answers the winning requester
//   with the resulting accumulator value.
//   Optional feature macro: ACC_SEQ_SCHED_OVF_EN (sticky wrap flag on STEP).
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     req_valid/req_ready per-requester command handshake (ready one-hot)
//     req_op/value/count  packed per-requester command fields
//     rsp_valid/rsp_ready response handshake
//     rsp_id/data/ovf     answered requester, result, wrap flag
//     acc_reset_l, acc_load, acc_inc, acc_in_data  accumulator controls
//     acc_out_data        accumulator value
// ---------------------------------------------------------------------------
module acc_seq_sched
    import acc_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [ACC_W*NUM_REQ-1:0] req_value,
    input  logic [CNT_W*NUM_REQ-1:0] req_count,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ACC_W-1:0]         rsp_data,
    output logic                     rsp_ovf,
    output logic                     acc_reset_l,
    output logic                     acc_load,
    output logic [ACC_W-1:0]         acc_inc,
    output logic [ACC_W-1:0]         acc_in_data,
    input  logic [ACC_W-1:0]         acc_out_data
);

    state_e           r_state;
    logic [ID_W-1:0]  r_ptr;
    op_e              r_op;
    logic [ACC_W-1:0] r_value;
    logic [CNT_W-1:0] r_remain;
    logic [ID_W-1:0]  r_id;
    logic             r_rspValid;
    logic             r_accResetL;
    logic             r_accLoad;
    logic [ACC_W-1:0] r_accInc;
    logic [ACC_W-1:0] r_accInData;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gidx;
    logic               w_any;
    logic [ID_W-1:0]    w_nextPtr;
    logic [1:0]         w_opArr    [NUM_REQ];
    logic [ACC_W-1:0]   w_valueArr [NUM_REQ];
    logic [CNT_W-1:0]   w_countArr [NUM_REQ];
    op_e                w_selOp;
    logic [ACC_W-1:0]   w_selValue;
    logic [CNT_W-1:0]   w_selCount;

    // Unpack the per-requester command fields so the winner can be
    // selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_opArr[g]    = req_op[2*g +: 2];
        assign w_valueArr[g] = req_value[ACC_W*g +: ACC_W];
        assign w_countArr[g] = req_count[CNT_W*g +: CNT_W];
    end

    assign w_selOp    = op_e'(w_opArr[w_gidx]);
    assign w_selValue = w_valueArr[w_gidx];
    assign w_selCount = w_countArr[w_gidx];

    // Grants only happen in IDLE and never while reset is held, so the
    // same-cycle ready strobe is quiet during reset.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    ((r_state == IDLE) && !reset),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_nextPtr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

    assign req_ready   = w_grant;
    assign rsp_valid   = r_rspValid;
    assign rsp_id      = r_id;
    assign acc_reset_l = r_accResetL;
    assign acc_load    = r_accLoad;
    assign acc_inc     = r_accInc;
    assign acc_in_data = r_accInData;

    // The accumulator has already absorbed the last EXEC cycle by the time
    // we reach RESP, so its output is the final result.
    assign rsp_data = (r_state == RESP) ? acc_out_data : '0;

    // Scheduler FSM. Accumulator controls are registered and loaded on the
    // transition into EXEC so they are active for exactly the EXEC cycles;
    // acc_inc stays 0 everywhere else because the accumulator adds it on
    // every non-load cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_op        <= CLR;
            r_value     <= '0;
            r_remain    <= '0;
            r_id        <= '0;
            r_rspValid  <= 1'b0;
            r_accResetL <= 1'b1;
            r_accLoad   <= 1'b0;
            r_accInc    <= '0;
            r_accInData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op     <= w_selOp;
                        r_value  <= w_selValue;
                        r_remain <= w_selCount;
                        r_id     <= w_gidx;
                        case (w_selOp)
                            CLR: begin
                                r_accResetL <= 1'b0;
                                r_state     <= EXEC;
                            end
                            LOAD: begin
                                r_accLoad   <= 1'b1;
                                r_accInData <= w_selValue;
                                r_state     <= EXEC;
                            end
                            STEP: begin
                                if (w_selCount == '0) begin
                                    r_rspValid <= 1'b1;
                                    r_state    <= RESP;
                                end else begin
                                    r_accInc <= w_selValue;
                                    r_state  <= EXEC;
                                end
                            end
                            default: begin
                                r_rspValid <= 1'b1;
                                r_state    <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (r_op == STEP) begin
                        if (r_remain == CNT_W'(1)) begin
                            r_accInc   <= '0;
                            r_rspValid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_remain <= r_remain - CNT_W'(1);
                        end
                    end else begin
                        r_accResetL <= 1'b1;
                        r_accLoad   <= 1'b0;
                        r_accInData <= '0;
                        r_rspValid  <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_ptr      <= w_nextPtr;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ACC_SEQ_SCHED_OVF_EN
    logic             r_ovf;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;

    assign w_sum   = {1'b0, acc_out_data} + {1'b0, r_value};
    assign w_carry = (w_sum > (ACC_W + 1)'(2**ACC_W - 1));

    // Sticky wrap flag: cleared when a new command is granted, set by any
    // STEP cycle whose add carries out of the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && w_any) begin
            r_ovf <= 1'b0;
        end else if ((r_state == EXEC) && (r_op == STEP) && w_carry) begin
            r_ovf <= 1'b1;
        end
    end

    assign rsp_ovf = r_ovf && (r_state == RESP);
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_acc_seq_sched.sv
// ---------------------------------------------------------------------------
// tb_acc_seq_sched
//   Self-checking bench for acc_seq_sched. Contains a behavioural model of
//   the load/increment accumulator driven by the scheduler, a monitor that
//   counts accumulator control activity, and a reference model of the
//   scheduler's results (accumulator value, round-robin order, wrap flag).
// ---------------------------------------------------------------------------
module tb_acc_seq_sched;
    import acc_seq_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

`ifdef ACC_SEQ_SCHED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_op;
    logic [8*NUM_REQ-1:0] req_value;
    logic [8*NUM_REQ-1:0] req_count;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_ovf;
    logic                 acc_reset_l;
    logic                 acc_load;
    logic [7:0]           acc_inc;
    logic [7:0]           acc_in_data;
    logic [7:0]           acc_out_data;

    logic [1:0] cmdOp  [NUM_REQ];
    logic [7:0] cmdVal [NUM_REQ];
    logic [7:0] cmdCnt [NUM_REQ];

    int nChecks = 0;
    int nFails  = 0;

    // Reference state: accumulator value and round-robin pointer.
    int expAcc = 0;
    int expPtr = 0;

    // Observations of the most recent command, filled by runOne.
    bit         obsTimeout;
    int         obsGrant;
    int         obsLat;
    logic [7:0] obsData;
    logic [1:0] obsId;
    logic       obsOvf;
    int         dInc, dIncSum, dLoad, dClr, dReady, dBad;

    // Free-running monitor counters, sampled on the falling edge.
    int         monInc = 0, monIncSum = 0, monLoad = 0, monClr = 0;
    int         monReady = 0, monBad = 0;
    logic [7:0] monLoadData = 8'h00;

    always #5 clk = ~clk;

    acc_seq_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_value    (req_value),
        .req_count    (req_count),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_ovf      (rsp_ovf),
        .acc_reset_l  (acc_reset_l),
        .acc_load     (acc_load),
        .acc_inc      (acc_inc),
        .acc_in_data  (acc_in_data),
        .acc_out_data (acc_out_data)
    );

    // Pack per-requester commands onto the DUT's flat ports.
    always_comb begin
        req_op    = '0;
        req_value = '0;
        req_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[2*i +: 2]    = cmdOp[i];
            req_value[8*i +: 8] = cmdVal[i];
            req_count[8*i +: 8] = cmdCnt[i];
        end
    end

    // Accumulator datapath model: synchronous active-low clear, load,
    // otherwise add inc every cycle. Not touched by the scheduler reset.
    logic [7:0] accQ = 8'h00;
    always @(posedge clk) begin
        if (!acc_reset_l)  accQ <= 8'h00;
        else if (acc_load) accQ <= acc_in_data;
        else               accQ <= accQ + acc_inc;
    end
    assign acc_out_data = accQ;

    // Count control activity so each command's footprint can be checked.
    always @(negedge clk) begin
        if (acc_inc != 8'h00) begin
            monInc++;
            monIncSum += int'(acc_inc);
        end
        if (acc_load) begin
            monLoad++;
            monLoadData = acc_in_data;
        end
        if (!acc_reset_l) monClr++;
        if (req_ready != '0) begin
            monReady++;
            if (!$onehot(req_ready)) monBad++;
        end
    end

    // First requester set in mask, searching upward from ptr with wrap.
    function automatic int expGrant(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic setCmd(input int id, input logic [1:0] op, input logic [7:0] val, input logic [7:0] cnt);
        cmdOp[id]     = op;
        cmdVal[id]    = val;
        cmdCnt[id]    = cnt;
        req_valid[id] = 1'b1;
    endtask

    // Drive one handshake round: wait for a grant, optionally drop the
    // winner's valid, wait for the response and accept it. Starts and ends
    // 1 time unit after a rising edge.
    task automatic runOne(input bit dropAfter);
        int k, sInc, sIncSum, sLoad, sClr, sReady, sBad;
        sInc = monInc; sIncSum = monIncSum; sLoad = monLoad;
        sClr = monClr; sReady = monReady; sBad = monBad;
        obsTimeout = 1'b0; obsGrant = -1; obsLat = 0;
        obsData = 8'h00; obsId = '0; obsOvf = 1'b0;
        k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 200) begin @(negedge clk); k++; end
        if (req_ready == '0) begin obsTimeout = 1'b1; return; end
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) obsGrant = i;
        @(posedge clk); #1;
        if (dropAfter) req_valid[obsGrant] = 1'b0;
        @(negedge clk);
        obsLat = 1; k = 0;
        while (!rsp_valid && k < 300) begin @(negedge clk); k++; obsLat++; end
        if (!rsp_valid) begin obsTimeout = 1'b1; return; end
        obsData = rsp_data; obsId = rsp_id; obsOvf = rsp_ovf;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        dInc = monInc - sInc; dIncSum = monIncSum - sIncSum; dLoad = monLoad - sLoad;
        dClr = monClr - sClr; dReady = monReady - sReady; dBad = monBad - sBad;
    endtask

    task automatic test_reset;
        reset = 1'b1; rsp_ready = 1'b0; req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin cmdOp[i] = 2'd0; cmdVal[i] = 8'h00; cmdCnt[i] = 8'h00; end
        repeat (2) @(negedge clk);
        nChecks++; if (req_ready !== 4'h0)   begin nFails++; $display("[TB] FAIL rst_req_ready: got %h want 0", req_ready); end
        nChecks++; if (rsp_valid !== 1'b0)   begin nFails++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        nChecks++; if (rsp_id !== 2'd0)      begin nFails++; $display("[TB] FAIL rst_rsp_id: got %0d want 0", rsp_id); end
        nChecks++; if (rsp_data !== 8'h00)   begin nFails++; $display("[TB] FAIL rst_rsp_data: got %h want 00", rsp_data); end
        nChecks++; if (rsp_ovf !== 1'b0)     begin nFails++; $display("[TB] FAIL rst_rsp_ovf: got %b want 0", rsp_ovf); end
        nChecks++; if (acc_reset_l !== 1'b1) begin nFails++; $display("[TB] FAIL rst_acc_reset_l: got %b want 1", acc_reset_l); end
        nChecks++; if (acc_load !== 1'b0)    begin nFails++; $display("[TB] FAIL rst_acc_load: got %b want 0", acc_load); end
        nChecks++; if (acc_inc !== 8'h00)    begin nFails++; $display("[TB] FAIL rst_acc_inc: got %h want 00", acc_inc); end
        nChecks++; if (acc_in_data !== 8'h00) begin nFails++; $display("[TB] FAIL rst_acc_in_data: got %h want 00", acc_in_data); end
        req_valid = 4'hF; for (int i = 0; i < NUM_REQ; i++) cmdOp[i] = 2'd3;
        #1;
        nChecks++; if (req_ready !== 4'h0)   begin nFails++; $display("[TB] FAIL rst_no_grant: got %h want 0", req_ready); end
        req_valid = '0;
        @(negedge clk); reset = 1'b0;
        expPtr = 0; expAcc = int'(accQ);
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        setCmd(0, 2'(LOAD), 8'h3C, 8'h00);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL load_timeout: got timeout want response"); return; end
        expAcc = 'h3C; expPtr = 1;
        nChecks++; if (obsGrant != 0)     begin nFails++; $display("[TB] FAIL load_grant: got %0d want 0", obsGrant); end
        nChecks++; if (dReady != 1)       begin nFails++; $display("[TB] FAIL load_ready_pulses: got %0d want 1", dReady); end
        nChecks++; if (dLoad != 1)        begin nFails++; $display("[TB] FAIL load_cycles: got %0d want 1", dLoad); end
        nChecks++; if (monLoadData !== 8'h3C) begin nFails++; $display("[TB] FAIL load_in_data: got %h want 3c", monLoadData); end
        nChecks++; if (obsData !== 8'h3C) begin nFails++; $display("[TB] FAIL load_rsp_data: got %h want 3c", obsData); end
        nChecks++; if (obsId !== 2'd0)    begin nFails++; $display("[TB] FAIL load_rsp_id: got %0d want 0", obsId); end
        nChecks++; if (obsLat != 2)       begin nFails++; $display("[TB] FAIL load_latency: got %0d want 2", obsLat); end
    endtask

    task automatic test_step;
        setCmd(1, 2'(LOAD), 8'h10, 8'h00);
        runOne(1'b1);
        nChecks++; if (obsData !== 8'h10) begin nFails++; $display("[TB] FAIL step_preload: got %h want 10", obsData); end
        setCmd(1, 2'(STEP), 8'h05, 8'd4);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL step_timeout: got timeout want response"); return; end
        expAcc = 'h24; expPtr = 2;
        nChecks++; if (dInc != 4)         begin nFails++; $display("[TB] FAIL step_inc_cycles: got %0d want 4", dInc); end
        nChecks++; if (dIncSum != 20)     begin nFails++; $display("[TB] FAIL step_inc_sum: got %0d want 20", dIncSum); end
        nChecks++; if (obsData !== 8'h24) begin nFails++; $display("[TB] FAIL step_rsp_data: got %h want 24", obsData); end
        nChecks++; if (obsId !== 2'd1)    begin nFails++; $display("[TB] FAIL step_rsp_id: got %0d want 1", obsId); end
        nChecks++; if (obsLat != 5)       begin nFails++; $display("[TB] FAIL step_latency: got %0d want 5", obsLat); end
        nChecks++; if (obsOvf !== 1'b0)   begin nFails++; $display("[TB] FAIL step_ovf: got %b want 0", obsOvf); end
    endtask

    task automatic test_ovf;
        setCmd(2, 2'(LOAD), 8'hC0, 8'h00);
        runOne(1'b1);
        setCmd(3, 2'(STEP), 8'h80, 8'd3);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL ovf_timeout: got timeout want response"); return; end
        expAcc = 'h40; expPtr = 0;
        nChecks++; if (obsData !== 8'h40)  begin nFails++; $display("[TB] FAIL ovf_rsp_data: got %h want 40", obsData); end
        nChecks++; if (obsOvf !== OVF_ON)  begin nFails++; $display("[TB] FAIL ovf_flag: got %b want %b", obsOvf, OVF_ON); end
        nChecks++; if (obsId !== 2'd3)     begin nFails++; $display("[TB] FAIL ovf_rsp_id: got %0d want 3", obsId); end
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < NUM_REQ; i++) setCmd(i, 2'(NOP), 8'($urandom), 8'($urandom));
        for (int n = 0; n < 5; n++) begin
            runOne(1'b0);
            nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL rr_timeout: got timeout want response"); break; end
            nChecks++; if (obsGrant != expPtr) begin nFails++; $display("[TB] FAIL rr_grant_%0d: got %0d want %0d", n, obsGrant, expPtr); end
            nChecks++; if (int'(obsId) != expPtr) begin nFails++; $display("[TB] FAIL rr_rsp_id_%0d: got %0d want %0d", n, obsId, expPtr); end
            nChecks++; if (int'(obsData) != expAcc) begin nFails++; $display("[TB] FAIL rr_rsp_data_%0d: got %h want %h", n, obsData, expAcc); end
            nChecks++; if (dInc != 0 || dLoad != 0 || dClr != 0) begin nFails++; $display("[TB] FAIL rr_nop_quiet_%0d: got inc=%0d load=%0d clr=%0d want 0", n, dInc, dLoad, dClr); end
            expPtr = (expPtr + 1) % NUM_REQ;
        end
        req_valid = '0;
    endtask

    task automatic test_step_zero_and_clr;
        setCmd(2, 2'(STEP), 8'h77, 8'd0);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL step0_timeout: got timeout want response"); return; end
        expPtr = 3;
        nChecks++; if (obsLat != 1)  begin nFails++; $display("[TB] FAIL step0_latency: got %0d want 1", obsLat); end
        nChecks++; if (dInc != 0)    begin nFails++; $display("[TB] FAIL step0_inc_cycles: got %0d want 0", dInc); end
        nChecks++; if (int'(obsData) != expAcc) begin nFails++; $display("[TB] FAIL step0_rsp_data: got %h want %h", obsData, expAcc); end
        nChecks++; if (obsOvf !== 1'b0) begin nFails++; $display("[TB] FAIL step0_ovf: got %b want 0", obsOvf); end
        setCmd(0, 2'(CLR), 8'h5A, 8'd9);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL clr_timeout: got timeout want response"); return; end
        expAcc = 0; expPtr = 1;
        nChecks++; if (dClr != 1)         begin nFails++; $display("[TB] FAIL clr_cycles: got %0d want 1", dClr); end
        nChecks++; if (obsData !== 8'h00) begin nFails++; $display("[TB] FAIL clr_rsp_data: got %h want 00", obsData); end
        nChecks++; if (obsLat != 2)       begin nFails++; $display("[TB] FAIL clr_latency: got %0d want 2", obsLat); end
    endtask

    task automatic test_reset_mid_step;
        logic [7:0] v;
        int k;
        bit sawRsp;
        v = 8'($urandom_range(1, 255));
        setCmd(1, 2'(STEP), v, 8'd10);
        k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 50) begin @(negedge clk); k++; end
        nChecks++; if (req_ready[1] !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_grant: got %h want 2", req_ready); end
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(posedge clk); #1; reset = 1'b1; #1;
        // One STEP cycle completed before reset landed in the second one.
        expAcc = (expAcc + int'(v)) % 256;
        nChecks++; if (acc_inc !== 8'h00)    begin nFails++; $display("[TB] FAIL midrst_acc_inc: got %h want 00", acc_inc); end
        nChecks++; if (acc_reset_l !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_acc_reset_l: got %b want 1", acc_reset_l); end
        nChecks++; if (rsp_valid !== 1'b0)   begin nFails++; $display("[TB] FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
        @(negedge clk); @(negedge clk); reset = 1'b0;
        expPtr = 0;
        sawRsp = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) sawRsp = 1'b1; end
        nChecks++; if (sawRsp) begin nFails++; $display("[TB] FAIL midrst_no_rsp: got rsp_valid=1 want 0"); end
        @(posedge clk); #1;
        setCmd(2, 2'(NOP), 8'h00, 8'h00);
        runOne(1'b1);
        nChecks++; if (int'(obsData) != expAcc) begin nFails++; $display("[TB] FAIL midrst_acc_kept: got %h want %h", obsData, expAcc); end
        expPtr = 3;
        setCmd(0, 2'(LOAD), 8'hA5, 8'h00);
        runOne(1'b1);
        nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL midrst_load_timeout: got timeout want response"); return; end
        expAcc = 'hA5; expPtr = 1;
        nChecks++; if (obsData !== 8'hA5) begin nFails++; $display("[TB] FAIL midrst_load_data: got %h want a5", obsData); end
        nChecks++; if (obsId !== 2'd0)    begin nFails++; $display("[TB] FAIL midrst_load_id: got %0d want 0", obsId); end
    endtask

    task automatic test_random_contention;
        int g, total, eData, eLat, eInc;
        bit eOvf;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] && ($urandom_range(0, 1) == 1))
                    setCmd(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 6)));
            if (req_valid == '0)
                setCmd(int'($urandom_range(0, 3)), 2'(STEP), 8'($urandom), 8'($urandom_range(0, 6)));
            g = expGrant(req_valid, expPtr);
            eOvf = 1'b0; eInc = 0; eLat = 2;
            case (cmdOp[g])
                2'd0: eData = 0;
                2'd1: eData = int'(cmdVal[g]);
                2'd2: begin
                    total = expAcc + int'(cmdCnt[g]) * int'(cmdVal[g]);
                    eData = total % 256;
                    eInc  = int'(cmdCnt[g]);
                    eLat  = (eInc == 0) ? 1 : eInc + 1;
                    eOvf  = OVF_ON && (eInc > 0) && (total > 255);
                end
                default: begin eData = expAcc; eLat = 1; end
            endcase
            runOne(1'b1);
            nChecks++; if (obsTimeout) begin nFails++; $display("[TB] FAIL rnd_timeout_%0d: got timeout want response", n); break; end
            nChecks++; if (obsGrant != g)          begin nFails++; $display("[TB] FAIL rnd_grant_%0d: got %0d want %0d", n, obsGrant, g); end
            nChecks++; if (int'(obsId) != g)       begin nFails++; $display("[TB] FAIL rnd_rsp_id_%0d: got %0d want %0d", n, obsId, g); end
            nChecks++; if (int'(obsData) != eData) begin nFails++; $display("[TB] FAIL rnd_rsp_data_%0d: got %h want %h", n, obsData, eData); end
            nChecks++; if (obsOvf !== eOvf)        begin nFails++; $display("[TB] FAIL rnd_ovf_%0d: got %b want %b", n, obsOvf, eOvf); end
            nChecks++; if (obsLat != eLat)         begin nFails++; $display("[TB] FAIL rnd_latency_%0d: got %0d want %0d", n, obsLat, eLat); end
            nChecks++; if (dInc != eInc)           begin nFails++; $display("[TB] FAIL rnd_inc_cycles_%0d: got %0d want %0d", n, dInc, eInc); end
            nChecks++; if (dReady != 1 || dBad != 0) begin nFails++; $display("[TB] FAIL rnd_ready_pulse_%0d: got pulses=%0d nonhot=%0d want 1/0", n, dReady, dBad); end
            expAcc = eData;
            expPtr = (g + 1) % NUM_REQ;
        end
        req_valid = '0;
    endtask

    initial begin
        $display("[TB] starting acc_seq_sched bench (ovf feature %0d)", OVF_ON);
        test_reset();
        test_load();
        test_step();
        test_ovf();
        test_round_robin();
        test_step_zero_and_clr();
        test_reset_mid_step();
        test_random_contention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
